hazard_unit_mc: RTL

Parametrised successor to the pipeline's combinational hazard unit, for the 5-stage core once multi-cycle memory and a multi-cycle mul/div unit (MDU) are added.
- Keeps E-stage forwarding selection (M over W, x0 excluded) and the branch/jump flush.
- Adds a counter-based load-use stall of configurable length.
- Adds a single-entry scoreboard that stalls decode on reads of a pending MDU destination.
- Sits beside the pipeline registers and drives their stall/flush enables.

---
 rtl/hazard_unit_mc_pkg.sv | 32 +++
 rtl/hazard_unit_mc_if.sv | 47 ++++
 rtl/hazard_unit_mc_stall_timer.sv | 61 ++++++
 rtl/hazard_unit_mc.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
//   fwd_sel_t    : E-stage operand source select (regfile / resultW / resultM)
//   load_state_t : load-use stall sub-FSM view
//   mdu_state_t  : MDU scoreboard sub-FSM view
//   tmr_state_t  : generic down-counter timer state
//   REG_ZERO     : architectural zero register index (never a real dependency)
package hazard_unit_mc_pkg;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    L_IDLE  = 1'b0,
    L_STALL = 1'b1
  } load_state_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_BUSY = 1'b1
  } mdu_state_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_BUSY = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side; drives register indices, enables and branch
//            resolution, receives forwarding selects and stall/flush enables.
//   slave  : hazard unit side; the mirror image of master.
interface hazard_unit_mc_if #(
  parameter int unsigned REG_ADDR_W = 5
);

  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e;
  logic [REG_ADDR_W-1:0] rs2_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [REG_ADDR_W-1:0] destReg_m;
  logic [REG_ADDR_W-1:0] destReg_w;
  logic                  memoryRead_e;
  logic                  mdu_start_e;
  logic                  regWrite_m;
  logic                  regWrite_w;
  logic                  zero_hazard;
  logic                  jump_hazard;

  logic [1:0]            forwardA_E;
  logic [1:0]            forwardB_E;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic                  mdu_busy;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, destReg_m, destReg_w,
    output memoryRead_e, mdu_start_e, regWrite_m, regWrite_w,
    output zero_hazard, jump_hazard,
    input  forwardA_E, forwardB_E, stall_f, stall_d, flush_d, flush_e,
    input  mdu_busy
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, destReg_m, destReg_w,
    input  memoryRead_e, mdu_start_e, regWrite_m, regWrite_w,
    input  zero_hazard, jump_hazard,
    output forwardA_E, forwardB_E, stall_f, stall_d, flush_d, flush_e,
    output mdu_busy
  );

endinterface

// File: rtl/hazard_unit_mc_stall_timer.sv
// Parametrised down-counter FSM used for both the load-use stall and the MDU
// scoreboard. start_i loads RELOAD and captures tag_i; the timer stays busy
// until the cycle in which the count is zero, then returns idle and drops the
// tag. clear_i aborts immediately and wins over start_i.
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : (re)load the counter and capture tag_i
//   clear_i   : abort to idle
//   tag_i     : value captured on start
//   busy_o    : timer running
//   last_o    : final busy cycle (count is zero)
//   tag_o     : captured tag, zero when idle
module hazard_unit_mc_stall_timer
  import hazard_unit_mc_pkg::*;
#(
  parameter int unsigned RELOAD = 0,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [TAG_W-1:0] tag_o
);

  tmr_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;

  // Single-process timer FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else if (clear_i) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else if (start_i) begin
      state_q <= T_BUSY;
      cnt_q   <= CNT_W'(RELOAD);
      tag_q   <= tag_i;
    end else if (state_q == T_BUSY) begin
      if (cnt_q == '0) begin
        state_q <= T_IDLE;
        tag_q   <= '0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy_o = (state_q == T_BUSY);
  assign last_o = (state_q == T_BUSY) && (cnt_q == '0);
  assign tag_o  = tag_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core with multi-cycle loads and a mul/div unit.
// Selects E-stage forwarding, stalls decode on load-use and on reads of a
// pending MDU destination, and flushes on taken branches / jumps.
//   clk, rst : clock, synchronous active-high reset (all outputs 0 while high)
//   hz       : pipeline bundle (slave side)
//     inputs : rs1_d, rs2_d, rs1_e, rs2_e, rd_e, destReg_m, destReg_w,
//              memoryRead_e, mdu_start_e, regWrite_m, regWrite_w,
//              zero_hazard, jump_hazard
//     outputs: forwardA_E, forwardB_E, stall_f, stall_d, flush_d, flush_e,
//              mdu_busy
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MDU_LAT    = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_mc_if.slave hz
);

  // The hit cycle itself is the first stall cycle, so the timer only covers
  // the remaining LOAD_LAT-1 cycles.
  localparam int unsigned LD_RELOAD = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
  localparam int unsigned MD_RELOAD = (MDU_LAT > 0) ? (MDU_LAT - 1) : 0;
  localparam logic        LD_MULTI  = (LOAD_LAT > 1);
  localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

  if ((LOAD_LAT < 1) || (MDU_LAT < 1)) begin : g_bad_lat
    $error("hazard_unit_mc: LOAD_LAT and MDU_LAT must be at least 1");
  end
  if ((LD_RELOAD >= (1 << CNT_W)) || (MD_RELOAD >= (1 << CNT_W))) begin : g_bad_cnt
    $error("hazard_unit_mc: CNT_W too narrow for LOAD_LAT/MDU_LAT");
  end

  fwd_sel_t              fwd_a;
  fwd_sel_t              fwd_b;
  logic                  flush_c;
  logic                  ld_hit;
  logic                  ld_busy;
  logic                  ld_last;
  logic                  ld_start;
  logic [REG_ADDR_W-1:0] ld_tag;
  load_state_t           lstate;
  logic                  load_stall;
  logic                  md_busy;
  logic                  md_last;
  logic                  md_start;
  logic [REG_ADDR_W-1:0] pend_rd;
  mdu_state_t            mstate;
  logic                  mdu_stall;
  logic                  stall_raw;
  logic                  flush_e_c;
  logic                  unused_load;

  // Forwarding: M result beats W result; x0 is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (hz.regWrite_m && (hz.destReg_m != RZ) && (hz.destReg_m == hz.rs1_e)) begin
      fwd_a = FWD_M;
    end else if (hz.regWrite_w && (hz.destReg_w != RZ) && (hz.destReg_w == hz.rs1_e)) begin
      fwd_a = FWD_W;
    end
    if (hz.regWrite_m && (hz.destReg_m != RZ) && (hz.destReg_m == hz.rs2_e)) begin
      fwd_b = FWD_M;
    end else if (hz.regWrite_w && (hz.destReg_w != RZ) && (hz.destReg_w == hz.rs2_e)) begin
      fwd_b = FWD_W;
    end
  end

  assign flush_c = hz.zero_hazard | hz.jump_hazard;

  // Load-use: stall starts combinationally on the hit; the timer extends it.
  assign ld_hit     = hz.memoryRead_e && (hz.rd_e != RZ) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  assign lstate     = ld_busy ? L_STALL : L_IDLE;
  assign load_stall = (lstate == L_STALL) || ld_hit;
  assign ld_start   = LD_MULTI && ld_hit && (lstate == L_IDLE) && !flush_c;

  hazard_unit_mc_stall_timer #(
    .RELOAD (LD_RELOAD),
    .CNT_W  (CNT_W),
    .TAG_W  (REG_ADDR_W)
  ) u_load_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (ld_start),
    .clear_i (flush_c),
    .tag_i   (hz.rd_e),
    .busy_o  (ld_busy),
    .last_o  (ld_last),
    .tag_o   (ld_tag)
  );

  // Load timer's tag/last are not needed; the stall ends on its own.
  assign unused_load = ^{ld_last, ld_tag};

  // MDU scoreboard: data hazard on pend_rd for the whole busy window, and a
  // structural hazard on a new issue except in the final busy cycle, where
  // the issue is accepted back-to-back.
  assign mstate    = md_busy ? M_BUSY : M_IDLE;
  assign mdu_stall = (mstate == M_BUSY) &&
                     (((pend_rd != RZ) &&
                       ((pend_rd == hz.rs1_d) || (pend_rd == hz.rs2_d))) ||
                      (hz.mdu_start_e && !md_last));

  assign stall_raw = load_stall | mdu_stall;
  assign flush_e_c = stall_raw | flush_c;
  assign md_start  = hz.mdu_start_e && !flush_e_c && ((mstate == M_IDLE) || md_last);

  // Not cleared by flush: the issuing instruction has already left E.
  hazard_unit_mc_stall_timer #(
    .RELOAD (MD_RELOAD),
    .CNT_W  (CNT_W),
    .TAG_W  (REG_ADDR_W)
  ) u_mdu_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .clear_i (1'b0),
    .tag_i   (hz.rd_e),
    .busy_o  (md_busy),
    .last_o  (md_last),
    .tag_o   (pend_rd)
  );

  // Flush beats stall; everything is held low during reset.
  assign hz.forwardA_E = rst ? 2'b00 : fwd_a;
  assign hz.forwardB_E = rst ? 2'b00 : fwd_b;
  assign hz.stall_f    = !rst && stall_raw && !flush_c;
  assign hz.stall_d    = !rst && stall_raw && !flush_c;
  assign hz.flush_d    = !rst && flush_c;
  assign hz.flush_e    = !rst && flush_e_c;
  assign hz.mdu_busy   = !rst && (mstate == M_BUSY);

endmodule
